// File: rtl/NetTypes.sv
// Shared packet word layout, address field widths and arbiter encodings for
// the network layer transmit path.
package NetTypes;

  localparam int DEVICE_ID_WIDTH = 4;
  localparam int USER_ID_WIDTH   = 3;
  localparam int ADDR_WIDTH      = DEVICE_ID_WIDTH + USER_ID_WIDTH;
  localparam int DATA_WIDTH      = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dest_addr;
  } PacketHeader;

  typedef struct packed {
    logic                  valid;
    logic                  first;
    logic                  last;
    PacketHeader           header;
    logic [DATA_WIDTH-1:0] data;
  } PacketWord;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE       = 2'd0;
  localparam arb_state_t ARB_GRANT_USER = 2'd1;
  localparam arb_state_t ARB_GRANT_PASS = 2'd2;

  typedef enum logic {
    SRC_USER = 1'b0,
    SRC_PASS = 1'b1
  } arb_src_e;

  function automatic logic [DEVICE_ID_WIDTH-1:0] dest_device(input PacketWord w);
    return w.header.dest_addr[ADDR_WIDTH-1:USER_ID_WIDTH];
  endfunction

endpackage

// File: rtl/packet_rr_arbiter.sv
// Two-requester round-robin arbiter that locks onto a source until the last
// word of its packet has been accepted.
module packet_rr_arbiter
  import NetTypes::*;
(
  input  logic clk,
  input  logic rst,
  input  logic user_req,
  input  logic pass_req,
  input  logic user_last_accept,
  input  logic pass_last_accept,
  output logic grant_user,
  output logic grant_pass,
  output logic idle
);

  arb_state_t state;
  arb_src_e   last_grant;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= SRC_PASS;
    end else begin
      case (state)
        ARB_IDLE: begin
          // On a tie the source that did not win last time goes first.
          if (user_req && (!pass_req || last_grant == SRC_PASS)) begin
            state      <= ARB_GRANT_USER;
            last_grant <= SRC_USER;
          end else if (pass_req) begin
            state      <= ARB_GRANT_PASS;
            last_grant <= SRC_PASS;
          end
        end
        ARB_GRANT_USER: if (user_last_accept) state <= ARB_IDLE;
        ARB_GRANT_PASS: if (pass_last_accept) state <= ARB_IDLE;
        default:        state <= ARB_IDLE;
      endcase
    end
  end

  assign grant_user = (state == ARB_GRANT_USER);
  assign grant_pass = (state == ARB_GRANT_PASS);
  assign idle       = (state == ARB_IDLE);

endmodule

// File: rtl/network_layer_tx.sv
// Merges local user packets and forwarded packets into one registered
// outbound stream, stamping the local device ID and dropping bad traffic.
module network_layer_tx
  import NetTypes::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DEVICE_ID_WIDTH-1:0] device_id,
  input  logic                       layer_programmed,
  input  logic [15:0]                NetSize,
  input  PacketWord                  user_layer_tx,
  output logic                       user_layer_tx_ready,
  input  PacketWord                  passing_packet_tx,
  output logic                       passing_packet_tx_ready,
  output PacketWord                  layer_tx,
  input  logic                       layer_tx_ready,
  output logic [7:0]                 layer_tx_error_status
);

  logic [DEVICE_ID_WIDTH-1:0] device_id_reg;
  logic                       drop_reg;
  logic                       grant_user, grant_pass, idle;
  logic                       out_free, bad_dest, user_dropping;
  logic                       user_acc, pass_acc, user_emit, pass_emit;
  logic                       orphan_user, orphan_pass, bad_evt;
  logic [1:0]                 err_inc;
  logic [8:0]                 err_sum;
  PacketWord                  stamped;

  assign out_free = ~layer_tx.valid | layer_tx_ready;
  assign bad_dest = layer_programmed &&
                    ({{(16-DEVICE_ID_WIDTH){1'b0}}, dest_device(user_layer_tx)} >= NetSize);
  // The drop decision is taken on the first word and remembered for the rest.
  assign user_dropping = user_layer_tx.first ? bad_dest : drop_reg;

  // Readys are forced low while reset is asserted, not just after the next edge.
  assign user_layer_tx_ready = ~rst &
    ((grant_user & (user_dropping | out_free)) |
     (idle & user_layer_tx.valid & ~user_layer_tx.first));
  assign passing_packet_tx_ready = ~rst &
    ((grant_pass & out_free) |
     (idle & passing_packet_tx.valid & ~passing_packet_tx.first));

  assign user_acc    = user_layer_tx.valid & user_layer_tx_ready;
  assign pass_acc    = passing_packet_tx.valid & passing_packet_tx_ready;
  assign user_emit   = grant_user & user_acc & ~user_dropping;
  assign pass_emit   = grant_pass & pass_acc;
  assign orphan_user = idle & user_acc;
  assign orphan_pass = idle & pass_acc;
  assign bad_evt     = grant_user & user_acc & user_layer_tx.first & bad_dest;
  assign err_inc     = {1'b0, orphan_user} + {1'b0, orphan_pass} + {1'b0, bad_evt};
  assign err_sum     = {1'b0, layer_tx_error_status} + {7'd0, err_inc};

  packet_rr_arbiter u_arbiter (
    .clk              (clk),
    .rst              (rst),
    .user_req         (user_layer_tx.valid & user_layer_tx.first),
    .pass_req         (passing_packet_tx.valid & passing_packet_tx.first),
    .user_last_accept (grant_user & user_acc & user_layer_tx.last),
    .pass_last_accept (pass_acc & passing_packet_tx.last & grant_pass),
    .grant_user       (grant_user),
    .grant_pass       (grant_pass),
    .idle             (idle)
  );

  // NOTE: the full default assignment first keeps this block latch-free.
  always_comb begin
    stamped = user_layer_tx;
    if (layer_programmed)
      stamped.header.src_addr[ADDR_WIDTH-1:USER_ID_WIDTH] = device_id_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_tx              <= '0;
      device_id_reg         <= '0;
      drop_reg              <= 1'b0;
      layer_tx_error_status <= 8'd0;
    end else begin
      device_id_reg <= device_id;
      if (user_emit)
        layer_tx <= stamped;
      else if (pass_emit)
        layer_tx <= passing_packet_tx;
      else if (layer_tx_ready)
        layer_tx.valid <= 1'b0;
      if (grant_user && user_acc)
        drop_reg <= user_dropping & ~user_layer_tx.last;
      layer_tx_error_status <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_network_layer_tx.sv
// Directed self-checking bench for network_layer_tx: arbitration, stamping,
// bad-dest drop, backpressure, orphan saturation and mid-packet reset.
module tb_network_layer_tx;
  import NetTypes::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  device_id;
  logic        layer_programmed;
  logic [15:0] NetSize;
  PacketWord   user_layer_tx, passing_packet_tx, layer_tx;
  logic        user_layer_tx_ready, passing_packet_tx_ready, layer_tx_ready;
  logic [7:0]  layer_tx_error_status;

  network_layer_tx dut (
    .clk                     (clk),
    .rst                     (rst),
    .device_id               (device_id),
    .layer_programmed        (layer_programmed),
    .NetSize                 (NetSize),
    .user_layer_tx           (user_layer_tx),
    .user_layer_tx_ready     (user_layer_tx_ready),
    .passing_packet_tx       (passing_packet_tx),
    .passing_packet_tx_ready (passing_packet_tx_ready),
    .layer_tx                (layer_tx),
    .layer_tx_ready          (layer_tx_ready),
    .layer_tx_error_status   (layer_tx_error_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int user_acc_cnt = 0, pass_acc_cnt = 0, out_valid_cnt = 0, overlap_cnt = 0;
  int first_acc_cyc = -1, first_out_cyc = -1;
  bit user_acc = 1'b0, pass_acc = 1'b0;
  PacketWord user_q[$], pass_q[$], out_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic PacketWord mk(input logic f, input logic l, input logic [6:0] s,
                                   input logic [6:0] d, input logic [31:0] dat);
    PacketWord w;
    w.valid = 1'b1; w.first = f; w.last = l;
    w.header.src_addr = s; w.header.dest_addr = d; w.data = dat;
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples handshakes half a cycle before the edge that commits them.
  initial forever begin
    @(negedge clk);
    user_acc = user_layer_tx.valid && user_layer_tx_ready;
    pass_acc = passing_packet_tx.valid && passing_packet_tx_ready;
    if (user_acc) user_acc_cnt++;
    if (pass_acc) pass_acc_cnt++;
    if (user_acc && first_acc_cyc < 0) first_acc_cyc = cyc;
    if (layer_tx.valid) out_valid_cnt++;
    if (layer_tx.valid && first_out_cyc < 0) first_out_cyc = cyc;
    if (layer_tx.valid && layer_tx_ready) out_q.push_back(layer_tx);
    if (user_layer_tx_ready && passing_packet_tx_ready) overlap_cnt++;
  end

  // Source drivers: present the next queued word once the current one is taken.
  initial begin
    user_layer_tx = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        user_layer_tx = '0;
        user_q.delete();
      end else if (user_acc || !user_layer_tx.valid) begin
        user_layer_tx = (user_q.size() > 0) ? user_q.pop_front() : '0;
      end
    end
  end

  initial begin
    passing_packet_tx = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        passing_packet_tx = '0;
        pass_q.delete();
      end else if (pass_acc || !passing_packet_tx.valid) begin
        passing_packet_tx = (pass_q.size() > 0) ? pass_q.pop_front() : '0;
      end
    end
  end

  task automatic wait_out(input int n, input int budget, input string tag);
    int k = 0;
    while (out_q.size() < n && k < budget) begin @(negedge clk); #1; k++; end
    check(tag, 64'(out_q.size() >= n), 64'd1);
  endtask

  task automatic wait_user(input int target, input int budget, input string tag);
    int k = 0;
    while (user_acc_cnt < target && k < budget) begin @(negedge clk); #1; k++; end
    check(tag, 64'(user_acc_cnt >= target), 64'd1);
  endtask

  task automatic wait_pass(input int target, input int budget, input string tag);
    int k = 0;
    while (pass_acc_cnt < target && k < budget) begin @(negedge clk); #1; k++; end
    check(tag, 64'(pass_acc_cnt >= target), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PacketWord exp_w[$];
    PacketWord snap;
    int base, ov, stall_bad;

    rst = 1'b1; device_id = 4'd5; layer_programmed = 1'b1; NetSize = 16'd8;
    layer_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(layer_tx.valid), 64'd0);
    check("rst_word", 64'(layer_tx), 64'd0);
    check("rst_uready", 64'(user_layer_tx_ready), 64'd0);
    check("rst_pready", 64'(passing_packet_tx_ready), 64'd0);
    check("rst_err", 64'(layer_tx_error_status), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Simultaneous 3-word packets: USER first (tie), stamped src device 5.
    first_acc_cyc = -1; first_out_cyc = -1;
    for (int i = 0; i < 3; i++) begin
      user_q.push_back(mk(i == 0, i == 2, {4'hA, 3'b101}, {4'd2, 3'd1}, 32'h1000 + i));
      pass_q.push_back(mk(i == 0, i == 2, {4'h3, 3'b010}, {4'd9, 3'd4}, 32'h2000 + i));
    end
    for (int i = 0; i < 3; i++)
      exp_w.push_back(mk(i == 0, i == 2, {4'd5, 3'b101}, {4'd2, 3'd1}, 32'h1000 + i));
    for (int i = 0; i < 3; i++)
      exp_w.push_back(mk(i == 0, i == 2, {4'h3, 3'b010}, {4'd9, 3'd4}, 32'h2000 + i));
    wait_out(6, 40, "arb_done");
    for (int i = 0; i < 6; i++)
      check($sformatf("arb_word%0d", i), 64'(out_q[i]), 64'(exp_w[i]));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("src_dev%0d", i), 64'(out_q[i].header.src_addr[6:3]), 64'd5);
      check($sformatf("src_usr%0d", i), 64'(out_q[i].header.src_addr[2:0]), 64'd5);
    end
    check("latency", 64'(first_out_cyc - first_acc_cyc), 64'd1);
    check("no_overlap", 64'(overlap_cnt), 64'd0);
    out_q.delete(); exp_w.delete();

    // Unprogrammed: single-word user packet passes unmodified and unchecked.
    layer_programmed = 1'b0;
    user_q.push_back(mk(1'b1, 1'b1, {4'hA, 3'b011}, {4'd15, 3'd0}, 32'hCAFE));
    wait_out(1, 20, "unprog_done");
    check("unprog_word", 64'(out_q[0]), 64'(mk(1'b1, 1'b1, {4'hA, 3'b011}, {4'd15, 3'd0}, 32'hCAFE)));
    check("unprog_err", 64'(layer_tx_error_status), 64'd0);
    out_q.delete();
    repeat (2) @(negedge clk);

    // Bad destination: whole 4-word packet swallowed, counted once.
    layer_programmed = 1'b1; NetSize = 16'd4;
    base = user_acc_cnt; ov = out_valid_cnt;
    for (int i = 0; i < 4; i++)
      user_q.push_back(mk(i == 0, i == 3, {4'h1, 3'b001}, {4'd7, 3'd0}, 32'h4000 + i));
    wait_user(base + 4, 40, "bad_done");
    repeat (3) @(negedge clk);
    #1;
    check("bad_accepts", 64'(user_acc_cnt - base), 64'd4);
    check("bad_no_out", 64'(out_valid_cnt - ov), 64'd0);
    check("bad_err", 64'(layer_tx_error_status), 64'd1);
    NetSize = 16'd8;

    // Backpressure: 10 stalled cycles mid-packet, then drain without loss.
    for (int i = 0; i < 6; i++) begin
      pass_q.push_back(mk(i == 0, i == 5, {4'h6, 3'b110}, {4'd1, 3'd2}, 32'h3000 + i));
      exp_w.push_back(mk(i == 0, i == 5, {4'h6, 3'b110}, {4'd1, 3'd2}, 32'h3000 + i));
    end
    wait_out(2, 30, "bp_start");
    @(posedge clk); #1 layer_tx_ready = 1'b0;
    @(negedge clk); #1 snap = layer_tx;
    stall_bad = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (layer_tx !== snap || passing_packet_tx_ready || user_layer_tx_ready) stall_bad++;
    end
    check("stall_valid", 64'(snap.valid), 64'd1);
    check("stall_stable", 64'(stall_bad), 64'd0);
    @(posedge clk); #1 layer_tx_ready = 1'b1;
    wait_out(6, 40, "bp_done");
    check("bp_count", 64'(out_q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("bp_word%0d", i), 64'(out_q[i]), 64'(exp_w[i]));
    out_q.delete(); exp_w.delete();
    repeat (3) @(negedge clk);

    // 300 orphan passing words: all dropped, counter saturates.
    base = pass_acc_cnt; ov = out_valid_cnt;
    for (int i = 0; i < 300; i++)
      pass_q.push_back(mk(1'b0, (i % 3) == 2, {4'h2, 3'b000}, {4'd1, 3'd0}, 32'h5000 + i));
    wait_pass(base + 300, 400, "orph_done");
    repeat (3) @(negedge clk);
    #1;
    check("orph_accepts", 64'(pass_acc_cnt - base), 64'd300);
    check("orph_no_out", 64'(out_valid_cnt - ov), 64'd0);
    check("orph_sat", 64'(layer_tx_error_status), 64'hFF);

    // Reset on word 2 of a 5-word packet; words 3-5 then arrive as orphans.
    base = user_acc_cnt;
    for (int i = 0; i < 5; i++)
      user_q.push_back(mk(i == 0, i == 4, {4'h9, 3'b100}, {4'd3, 3'd0}, 32'h6000 + i));
    wait_user(base + 1, 20, "rst_w1");
    @(posedge clk); #2;
    check("pre_rst_valid", 64'(layer_tx.valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(layer_tx.valid), 64'd0);
    check("mid_rst_fl", 64'({layer_tx.first, layer_tx.last}), 64'd0);
    check("mid_rst_readys", 64'({user_layer_tx_ready, passing_packet_tx_ready}), 64'd0);
    check("mid_rst_err", 64'(layer_tx_error_status), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    out_q.delete();
    base = user_acc_cnt; ov = out_valid_cnt;
    for (int i = 2; i < 5; i++)
      user_q.push_back(mk(1'b0, i == 4, {4'h9, 3'b100}, {4'd3, 3'd0}, 32'h6000 + i));
    wait_user(base + 3, 20, "resub_done");
    repeat (3) @(negedge clk);
    #1;
    check("resub_err", 64'(layer_tx_error_status), 64'd3);
    check("resub_no_out", 64'(out_valid_cnt - ov), 64'd0);
    check("final_overlap", 64'(overlap_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/network_layer_tx.md
NETWORK_LAYER_TX -- requirements
Module: network_layer_tx

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 device_id  in  DEVICE_ID_WIDTH  local device ID; registered into device_id_reg each cycle.
REQ-004 layer_programmed  in  1  high: address stamping and dest checking enabled; low: user packets pass unmodified and unchecked.
REQ-005 NetSize  in  16  number of devices in the network; a dest device field >= NetSize is invalid.
REQ-006 user_layer_tx  in  PacketWord  packet words from the local user layer.
REQ-007 user_layer_tx_ready  out  1  word on user_layer_tx accepted when valid & ready.
REQ-008 passing_packet_tx  in  PacketWord  forwarded words from the receive side, destined elsewhere.
REQ-009 passing_packet_tx_ready  out  1  word on passing_packet_tx accepted when valid & ready.
REQ-010 layer_tx  out  PacketWord  merged outbound stream, registered.
REQ-011 layer_tx_ready  in  1  downstream accepts layer_tx when layer_tx.valid & layer_tx_ready.
REQ-012 layer_tx_error_status  out  8  saturating count of dropped user packets (bad dest) plus dropped orphan words.

Function
REQ-013 Arbiter FSM states: IDLE, GRANT_USER, GRANT_PASS.
REQ-014 IDLE: a source is eligible when valid & first; if both are eligible, the source not granted last is chosen (round-robin, last_grant resets to PASS, so USER wins the first tie).
REQ-015 Grant holds until a word with last=1 from the granted source is accepted; the FSM then returns to IDLE on the next cycle.
REQ-016 A single-word packet (first & last) is granted and completed in one handshake.
REQ-017 The non-granted source sees ready=0 for the whole packet; words are never interleaved between packets.
REQ-018 In IDLE, a valid word with first=0 (orphan) is consumed (ready=1), dropped, and counted; the FSM stays in IDLE.
REQ-019 Output stage is a single register: input ready = granted & (~layer_tx.valid | layer_tx_ready); latency is exactly 1 cycle from input handshake to layer_tx.valid.
REQ-020 Throughput is one word per cycle under continuous ready; no bubble between consecutive packets of the same source beyond the one IDLE cycle.
REQ-021 User packets with layer_programmed=1 have header.src_addr[DEVICE_ID_WIDTH+USER_ID_WIDTH-1:USER_ID_WIDTH] overwritten with device_id_reg on every word; user bits are unchanged.
REQ-022 Passing packets are forwarded bit-exact (data, header, first, last).
REQ-023 User packet with layer_programmed=1 and dest device field >= NetSize on its first word: the whole packet is consumed at full rate (ready=1), never emitted, and the counter increments once per packet.
REQ-024 Error counter saturates at 8'hFF; simultaneous orphan and bad-dest events in the same cycle add 1 each, still saturating.
REQ-025 layer_tx.valid holds and data are stable while layer_tx_ready=0.

Reset
REQ-026 On rst: FSM=IDLE, last_grant=PASS, layer_tx.valid=0, layer_tx first/last=0, both readys=0, error counter=0, device_id_reg=0.
REQ-027 Reset asserted mid-packet aborts it; after release, continuation words without first are treated as orphans.

Structure
REQ-028 PacketWord, the header src_addr/dest_addr fields, DEVICE_ID_WIDTH and USER_ID_WIDTH live in NetTypes; the arbiter state enum is also placed in NetTypes.
REQ-029 A single sub-module, packet_rr_arbiter (two-requester, packet-locked round-robin), is natural; the output register stays in the top module.

Verification
REQ-030 Both sources present 3-word packets at the same time after reset -> the USER packet is emitted first, then PASS, with no interleaving; output starts 1 cycle after the first accept.
REQ-031 device_id=5, layer_programmed=1, user dest device=2, src user bits=3'b101 -> every output word has src device=5 and user bits=3'b101.
REQ-032 NetSize=4, user dest device=7, 4-word packet -> 4 accepts, no layer_tx.valid, error_status increments 0->1.
REQ-033 layer_tx_ready held low for 10 cycles mid-packet -> layer_tx is stable, input readys are 0, and no word is lost or duplicated after release.
REQ-034 Orphan passing word (first=0) in IDLE, 300 times -> dropped each time, error_status saturates at 255.
REQ-035 rst pulsed on word 2 of a 5-word packet -> outputs cleared at once; resubmitted words 3-5 (no first) are counted as orphans.
